// File: rtl/counter_9316.sv
// 9316/74161 4-bit synchronous presettable binary counter, emulated on the fast
// CLK_DRV clock. The IC clock CLK is sampled as data and its rising edges are detected.
module counter_9316 #(
  parameter logic [3:0] Q_INIT = 4'd0
) (
  input  logic       CLK_DRV,
  input  logic       RST_N,
  input  logic       CLK,
  input  logic       CLR_N,
  input  logic       LOAD_N,
  input  logic       ENP,
  input  logic       ENT,
  input  logic [3:0] D,
  output logic [3:0] Q,
  output logic       RCO
);

  logic [3:0] r_q;
  logic       r_clk_prev;
  logic       w_edge;
  logic [3:0] w_q_next;

  assign w_edge = CLK & ~r_clk_prev;

  // Clear dominates everything; an edge seen during clear is consumed, not deferred.
  always_comb begin
    w_q_next = r_q;
    if (!CLR_N) begin
      w_q_next = 4'd0;
    end else if (w_edge) begin
      if (!LOAD_N) begin
        w_q_next = D;
      end else if (ENP && ENT) begin
        w_q_next = r_q + 4'd1;
      end
    end
  end

  // clk_prev resets high so a CLK already high at reset release is not an edge.
  always_ff @(posedge CLK_DRV) begin
    if (!RST_N) begin
      r_q        <= Q_INIT;
      r_clk_prev <= 1'b1;
    end else begin
      r_q        <= w_q_next;
      r_clk_prev <= CLK;
    end
  end

  assign Q   = r_q;
  assign RCO = ENT & (r_q == 4'hF);

endmodule

// File: tb/tb_counter_9316.sv
// Directed bench for counter_9316: a stand-alone counter plus a two-stage cascade,
// checked every cycle against a behavioural model and at key points against literals.
module tb_counter_9316;

  logic       clk_drv = 1'b0;
  logic       rst_n, clk, clr_n, load_n, enp, ent;
  logic [3:0] d;
  logic [3:0] q, q_lo, q_hi;
  logic       rco, rco_lo, rco_hi;

  int checks   = 0;
  int failures = 0;

  // ---------------- clock ----------------
  always #5 clk_drv = ~clk_drv;

  // ---------------- DUTs ----------------
  counter_9316 dut (
    .CLK_DRV(clk_drv), .RST_N(rst_n), .CLK(clk), .CLR_N(clr_n),
    .LOAD_N(load_n), .ENP(enp), .ENT(ent), .D(d), .Q(q), .RCO(rco)
  );

  counter_9316 u_lo (
    .CLK_DRV(clk_drv), .RST_N(rst_n), .CLK(clk), .CLR_N(1'b1),
    .LOAD_N(1'b1), .ENP(1'b1), .ENT(1'b1), .D(4'd0), .Q(q_lo), .RCO(rco_lo)
  );

  counter_9316 u_hi (
    .CLK_DRV(clk_drv), .RST_N(rst_n), .CLK(clk), .CLR_N(1'b1),
    .LOAD_N(1'b1), .ENP(rco_lo), .ENT(rco_lo), .D(4'd0), .Q(q_hi), .RCO(rco_hi)
  );

  // Set/reset flip-flop downstream of the cascade: set by the high stage's carry.
  logic srff_q;
  always @(posedge clk_drv) begin
    if (!rst_n)      srff_q <= 1'b0;
    else if (rco_hi) srff_q <= 1'b1;
  end

  // ---------------- behavioural model ----------------
  // m_q: stand-alone counter value; m_total: count of IC clock edges seen by the cascade.
  int   m_q;
  int   m_total;
  logic m_clk_seen;
  logic started = 1'b0;

  always @(posedge clk_drv) begin
    started <= 1'b1;
    if (!rst_n) begin
      m_q        <= 0;
      m_total    <= 0;
      m_clk_seen <= 1'b1;
    end else begin
      m_clk_seen <= clk;
      if (clk && !m_clk_seen) m_total <= (m_total + 1) % 256;
      if (!clr_n)
        m_q <= 0;
      else if (clk && !m_clk_seen) begin
        if (!load_n)         m_q <= int'(d);
        else if (enp && ent) m_q <= (m_q + 1) % 16;
      end
    end
  end

  // ---------------- scoreboard ----------------
  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk_drv) begin
    if (started) begin
      check("model_q",      {4'd0, q},       8'(m_q));
      check("model_rco",    {7'd0, rco},     {7'd0, ent && (m_q == 15)});
      check("model_casc",   {q_hi, q_lo},    8'(m_total));
      check("model_rco_hi", {7'd0, rco_hi},  {7'd0, m_total == 255});
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step(input int n);
    repeat (n) @(posedge clk_drv);
    #1;
  endtask

  // One full IC clock period: rising edge, settle, fall.
  task automatic clk_pulse();
    clk = 1'b1;
    step(1);
    clk = 1'b0;
    step(1);
  endtask

  task automatic load_value(input logic [3:0] v);
    load_n = 1'b0;
    d      = v;
    clk_pulse();
    load_n = 1'b1;
  endtask

  // ---------------- directed stimulus ----------------
  initial begin
    rst_n = 1'b0; clk = 1'b0; clr_n = 1'b1; load_n = 1'b1;
    enp = 1'b1; ent = 1'b1; d = 4'd0;

    // Reset with CLK toggling
    step(1);
    clk = 1'b1; step(1);
    check("reset_q", {4'd0, q}, 8'd0);
    clk = 1'b0; step(1);
    check("reset_q2", {4'd0, q}, 8'd0);
    clk = 1'b1; step(1);
    rst_n = 1'b1; step(2);
    check("no_count_high_at_release", {4'd0, q}, 8'd0);
    clk = 1'b0; step(1);
    clk = 1'b1; step(1);
    check("first_count", {4'd0, q}, 8'd1);
    clk = 1'b0; step(1);

    // Count through the wrap: 2..15,0,1,2
    for (int i = 0; i < 17; i++) begin
      clk_pulse();
      check("count_seq", {4'd0, q}, 8'((i + 2) % 16));
      check("count_rco", {7'd0, rco}, {7'd0, ((i + 2) % 16) == 15});
    end
    check("count_end", {4'd0, q}, 8'd2);

    // Enables
    load_value(4'd5);
    check("load5", {4'd0, q}, 8'd5);
    enp = 1'b0;
    repeat (3) clk_pulse();
    check("enp0_hold", {4'd0, q}, 8'd5);
    check("enp0_rco", {7'd0, rco}, 8'd0);
    enp = 1'b1; ent = 1'b0;
    load_value(4'hF);
    check("ent0_q15", {4'd0, q}, 8'd15);
    check("ent0_rco", {7'd0, rco}, 8'd0);
    clk_pulse();
    check("ent0_hold", {4'd0, q}, 8'd15);
    ent = 1'b1; #1;
    check("ent_rise_rco", {7'd0, rco}, 8'd1);
    step(1);

    // Load 12 with ENP low, then count 13,14,15,0
    enp = 1'b0;
    load_value(4'hC);
    check("load12", {4'd0, q}, 8'd12);
    enp = 1'b1;
    for (int i = 0; i < 4; i++) begin
      clk_pulse();
      check("post_load_count", {4'd0, q}, 8'((13 + i) % 16));
    end

    // Clear between edges, edge during clear is consumed
    load_value(4'd9);
    check("load9", {4'd0, q}, 8'd9);
    clr_n = 1'b0; step(1);
    check("clear_q", {4'd0, q}, 8'd0);
    load_n = 1'b0; d = 4'd7;
    clk_pulse();
    check("clear_blocks_load", {4'd0, q}, 8'd0);
    clr_n = 1'b1; load_n = 1'b1; step(1);
    check("clear_release_hold", {4'd0, q}, 8'd0);
    clk_pulse();
    check("after_clear_count", {4'd0, q}, 8'd1);

    // Cascade: fresh reset, 255 edges then one more
    rst_n = 1'b0; step(2);
    rst_n = 1'b1; step(1);
    check("casc_reset", {q_hi, q_lo}, 8'd0);
    for (int i = 0; i < 255; i++) begin
      clk_pulse();
      if (q_lo != 4'd0 || i == 254)
        check("casc_hi_steady", {4'd0, q_hi}, 8'((i + 1) / 16));
    end
    check("casc_255", {q_hi, q_lo}, 8'd255);
    check("casc_rco_hi", {7'd0, rco_hi}, 8'd1);
    clk_pulse();
    check("casc_wrap", {q_hi, q_lo}, 8'd0);
    check("srff_set", {7'd0, srff_q}, 8'd1);

    step(2);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
